// File: rtl/alu_wb_buffer_pkg.sv
// Shared types and defaults for the ALU writeback staging buffer.
// Holds the result-entry layout and the modulo pointer helper.
package alu_wb_buffer_pkg;

  localparam int unsigned DEFAULT_XLEN          = 64;
  localparam int unsigned DEFAULT_TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0]          result;
    logic                             branch_res;
    logic [DEFAULT_TRANS_ID_BITS-1:0] trans_id;
  } alu_wb_entry_t;

  // Works for any depth, not only powers of two.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/alu_wb_buffer.sv
// In-order result staging FIFO between the ALU and the writeback port, with flush.
// Define ALU_WB_BYPASS_EN to forward a result combinationally when the buffer is empty.
module alu_wb_buffer
  import alu_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned XLEN          = DEFAULT_XLEN,
  parameter int unsigned TRANS_ID_BITS = DEFAULT_TRANS_ID_BITS,
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CNT_W-1:0]         count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Same layout as alu_wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic                     branch_res;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  entry_t in_entry, head;
  logic   empty, full, push, pop;

  assign in_entry = '{result: alu_result_i, branch_res: alu_branch_res_i, trans_id: alu_trans_id_i};
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

  assign alu_ready_o = ~full & ~rst_i;
  assign count_o     = count_q;

`ifdef ALU_WB_BYPASS_EN
  logic bypass;
  assign bypass = empty & alu_valid_i & ~flush_i & ~rst_i;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    wb_valid_o = ~empty & ~flush_i;
    head       = mem_q[rd_ptr_q];
    pop        = wb_valid_o & wb_ready_i;
    push       = alu_valid_i & alu_ready_o;
`ifdef ALU_WB_BYPASS_EN
    // Empty buffer: the live ALU result is the head; store it only if writeback stalls.
    if (bypass) begin
      wb_valid_o = 1'b1;
      head       = in_entry;
      pop        = 1'b0;
      push       = ~wb_ready_i;
    end
`endif
  end

  assign wb_result_o     = head.result;
  assign wb_branch_res_o = head.branch_res;
  assign wb_trans_id_o   = head.trans_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage is reset too, because the head is visible on wb_* and must read 0 in reset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= PTR_W'(ptr_wrap_inc(int'(wr_ptr_q), DEPTH));
      end
      if (pop) rd_ptr_q <= PTR_W'(ptr_wrap_inc(int'(rd_ptr_q), DEPTH));
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer (DEPTH=3): table vectors, corner sequences,
// and randomized traffic against a queue model; follows ALU_WB_BYPASS_EN if defined.
module tb_alu_wb_buffer;
  import alu_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned XLEN  = DEFAULT_XLEN;
  localparam int unsigned TID   = DEFAULT_TRANS_ID_BITS;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst, flush, alu_valid, alu_ready, alu_branch_res;
  logic            wb_valid, wb_ready, wb_branch_res;
  logic [XLEN-1:0] alu_result, wb_result;
  logic [TID-1:0]  alu_trans_id, wb_trans_id;
  logic [CNT_W-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  alu_wb_entry_t model_q[$];

  logic            s_valid, s_ready, s_branch;
  logic [XLEN-1:0] s_result;
  logic [TID-1:0]  s_id;
  int              s_count;

  typedef struct {
    logic            v;
    logic [XLEN-1:0] res;
    logic [TID-1:0]  id;
    logic            rdy;
    logic            exp_valid;
    logic [XLEN-1:0] exp_res;
    logic [TID-1:0]  exp_id;
    int              exp_count;
    logic            exp_ready;
  } vec_t;

  always #5 clk = ~clk;

  alu_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TID)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .alu_valid_i     (alu_valid),
    .alu_ready_o     (alu_ready),
    .alu_result_i    (alu_result),
    .alu_branch_res_i(alu_branch_res),
    .alu_trans_id_i  (alu_trans_id),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_result_o     (wb_result),
    .wb_branch_res_o (wb_branch_res),
    .wb_trans_id_o   (wb_trans_id),
    .count_o         (count)
  );

  always @(posedge clk)
    if (!rst) assert (!(alu_valid && !alu_ready))
      else $error("producer presented alu_valid while alu_ready_o was low");

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the queue model, then let the edge happen.
  task automatic apply(input logic v, input logic [XLEN-1:0] res, input logic br,
                       input logic [TID-1:0] id, input logic rdy, input logic fl);
    alu_wb_entry_t in_e, exp_head;
    logic exp_ready, exp_valid, byp;
    @(negedge clk);
    alu_valid = v; alu_result = res; alu_branch_res = br; alu_trans_id = id;
    wb_ready = rdy; flush = fl;
    #1;
    s_valid = wb_valid; s_ready = alu_ready; s_result = wb_result;
    s_branch = wb_branch_res; s_id = wb_trans_id; s_count = int'(count);
    in_e = '{result: res, branch_res: br, trans_id: id};
    exp_ready = model_q.size() < DEPTH;
    byp = 1'b0;
`ifdef ALU_WB_BYPASS_EN
    byp = (model_q.size() == 0) && v && !fl;
`endif
    exp_valid = ((model_q.size() != 0) && !fl) || byp;
    exp_head  = byp ? in_e : ((model_q.size() != 0) ? model_q[0] : '0);
    check("model_count", count, model_q.size());
    check("model_alu_ready", alu_ready, exp_ready);
    check("model_wb_valid", wb_valid, exp_valid);
    check("model_count_bound", count <= DEPTH, 1);
    if (exp_valid) begin
      check("model_wb_trans_id", wb_trans_id, exp_head.trans_id);
      check("model_wb_result", wb_result, exp_head.result);
      check("model_wb_branch", wb_branch_res, exp_head.branch_res);
    end
    if (fl) model_q.delete();
    else if (!(byp && rdy)) begin
      if (exp_valid && rdy) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back(in_e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic rdy);
    apply(1'b0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{1'b1, 64'hDEAD_BEEF, 3'd3, 1'b1, 1'b0, '0,          3'd0, 0, 1'b1};
    tbl[1] = '{1'b0, '0,            3'd0, 1'b1, 1'b1, 64'hDEAD_BEEF, 3'd3, 1, 1'b1};
    tbl[2] = '{1'b0, '0,            3'd0, 1'b1, 1'b0, '0,          3'd0, 0, 1'b1};
`ifdef ALU_WB_BYPASS_EN
    tbl[0] = '{1'b1, 64'hDEAD_BEEF, 3'd3, 1'b1, 1'b1, 64'hDEAD_BEEF, 3'd3, 0, 1'b1};
    tbl[1] = '{1'b0, '0,            3'd0, 1'b1, 1'b0, '0,          3'd0, 0, 1'b1};
`endif

    rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; alu_result = '0;
    alu_branch_res = 1'b0; alu_trans_id = '0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_count", count, 0);
    check("rst_wb_result", wb_result, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("release_alu_ready", alu_ready, 1);

    // Single result with writeback ready.
    for (int i = 0; i < 3; i++) begin
      apply(tbl[i].v, tbl[i].res, 1'b0, tbl[i].id, tbl[i].rdy, 1'b0);
      check("tbl_wb_valid", s_valid, tbl[i].exp_valid);
      check("tbl_count", s_count, tbl[i].exp_count);
      check("tbl_alu_ready", s_ready, tbl[i].exp_ready);
      if (tbl[i].exp_valid) begin
        check("tbl_wb_result", s_result, tbl[i].exp_res);
        check("tbl_wb_trans_id", s_id, tbl[i].exp_id);
      end
    end

    // Fill with writeback stalled, then drain in order.
    for (int i = 1; i <= 3; i++) apply(1'b1, 64'h100 + i, i[0], TID'(i), 1'b0, 1'b0);
    idle(1'b0);
    check("full_alu_ready", s_ready, 0);
    check("full_count", s_count, 3);
    check("full_head", s_id, 1);
    idle(1'b0);
    check("full_head_stable", s_id, 1);
    for (int i = 1; i <= 3; i++) begin
      idle(1'b1);
      check("drain_order", s_id, TID'(i));
      check("drain_result", s_result, 64'h100 + i);
    end
    idle(1'b1);
    check("drained_valid", s_valid, 0);

    // Flush with two entries and a simultaneous push.
    apply(1'b1, 64'h44, 1'b0, 3'd4, 1'b0, 1'b0);
    apply(1'b1, 64'h55, 1'b1, 3'd5, 1'b0, 1'b0);
    apply(1'b1, 64'h66, 1'b0, 3'd6, 1'b1, 1'b1);
    check("flush_cycle_valid", s_valid, 0);
    check("flush_cycle_count", s_count, 2);
    idle(1'b1);
    check("post_flush_count", s_count, 0);
    check("post_flush_valid", s_valid, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("flushed_never_seen", s_valid, 0);
    end

    // Random traffic across many pointer wraps.
    for (int n = 0; n < 400; n++) begin
      logic v, rdy, fl;
      v   = ($urandom_range(0, 1) == 1) && (model_q.size() < DEPTH);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 39) == 0);
      apply(v, {$urandom, $urandom}, 1'($urandom), TID'($urandom), rdy, fl);
    end

    // Asynchronous reset mid-cycle while full.
    apply(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply(1'b1, {$urandom, 32'hA5A5_0000 + i}, 1'b1, TID'(i + 5), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_wb_valid", wb_valid, 0);
    check("arst_wb_result", wb_result, 0);
    check("arst_wb_branch", wb_branch_res, 0);
    check("arst_wb_trans_id", wb_trans_id, 0);
    check("arst_count", count, 0);
    check("arst_alu_ready", alu_ready, 0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("arst_release_ready", alu_ready, 1);
    idle(1'b1);
    apply(1'b1, 64'h77, 1'b0, 3'd7, 1'b1, 1'b0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
